// File: rtl/sdram_resp_pkg.sv
// sdram_resp_pkg: shared types for the SDRAM weight responder.
//   state_t   - responder FSM states
//   WORDS_DEF - default words per weight line
//   line_t    - one packed 16x16-bit weight line
package sdram_resp_pkg;
    localparam int WORDS_DEF = 16;
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    typedef logic [15:0][15:0] line_t;
endpackage

// File: rtl/sdram_weight_responder_line_assembler.sv
// line_assembler: collects in-order read responses into a shadow line and publishes it whole.
//   clk, reset  - clock, async active-high reset
//   start       - clears the receive count for a new line
//   issue_cnt   - number of word reads accepted by memory for this line
//   rdata/rvalid- memory read response
//   rd_buf      - last completed line
//   done        - combinational: this cycle's response completes the line
//   err         - sticky: response seen with nothing outstanding
module line_assembler #(
    parameter int WORDS = 16,
    parameter int CW    = $clog2(WORDS) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CW-1:0]          issue_cnt,
    input  logic [15:0]            rdata,
    input  logic                   rvalid,
    output logic [WORDS-1:0][15:0] rd_buf,
    output logic                   done,
    output logic                   err
);
    logic [CW-1:0]          recv_cnt;
    logic [WORDS-1:0][15:0] shadow, shadow_nxt;
    logic                   take;

    assign take = rvalid && (issue_cnt != recv_cnt);
    assign done = take && (recv_cnt == CW'(WORDS - 1));

    // the completing word is merged here so rd_buf gets it in the same edge
    always_comb begin
        shadow_nxt = shadow;
        if (take) shadow_nxt[recv_cnt[CW-2:0]] = rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recv_cnt <= '0;
            shadow   <= '0;
            rd_buf   <= '0;
            err      <= 1'b0;
        end else begin
            if (start) recv_cnt <= '0;
            else if (take) recv_cnt <= recv_cnt + 1'b1;
            if (take) shadow <= shadow_nxt;
            if (done) rd_buf <= shadow_nxt;
            if (rvalid && !take) err <= 1'b1;
        end
    end
endmodule

// File: rtl/sdram_weight_responder.sv
// sdram_weight_responder: fetches one weight line per rd_req from a word-addressed memory port.
//   clk, reset           - clock, async active-high reset
//   rd_req               - line request (level or pulse)
//   rd_buf, rd_done      - assembled line and its one-cycle valid pulse
//   base_addr, base_load - weight table base and its load strobe
//   num_lines            - lines before the pointer wraps to base (0 = never)
//   mem_rd, mem_addr, mem_ready, mem_rdata, mem_rvalid - memory port
//   busy, err            - FSM not idle; sticky unexpected-response flag
module sdram_weight_responder
    import sdram_resp_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int WORDS   = WORDS_DEF,
    parameter int LINES_W = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_req,
    output logic [WORDS-1:0][15:0] rd_buf,
    output logic                   rd_done,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   base_load,
    input  logic [LINES_W-1:0]     num_lines,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ready,
    input  logic [15:0]            mem_rdata,
    input  logic                   mem_rvalid,
    output logic                   busy,
    output logic                   err
);
    localparam int CW = $clog2(WORDS) + 1;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, pend_base, load_base;
    logic [LINES_W-1:0]  line_cnt, cnt_inc;
    logic [CW-1:0]       issue_cnt;
    logic                pend_req, pend_load, load_now, start, done_line;

    line_assembler #(.WORDS(WORDS), .CW(CW)) u_asm (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .issue_cnt (issue_cnt),
        .rdata     (mem_rdata),
        .rvalid    (mem_rvalid),
        .rd_buf    (rd_buf),
        .done      (done_line),
        .err       (err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        mem_rd    = 1'b0;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                start     = rd_req || pend_req;
                state_nxt = start ? FETCH : IDLE;
            end
            FETCH: begin
                mem_rd    = issue_cnt < CW'(WORDS);
                state_nxt = done_line ? DONE : FETCH;
            end
            DONE: begin
                rd_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = state != IDLE;
    assign mem_addr  = mem_rd ? ptr + ADDR_W'(issue_cnt) : '0;
    assign cnt_inc   = line_cnt + 1'b1;
    // a load arriving in the DONE cycle itself is newer than any pending one
    assign load_now  = pend_load || base_load;
    assign load_base = base_load ? base_addr : pend_base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            line_cnt  <= '0;
            issue_cnt <= '0;
            pend_req  <= 1'b0;
            pend_load <= 1'b0;
            pend_base <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (base_load) begin
                        ptr      <= base_addr;
                        line_cnt <= '0;
                    end
                    if (start) begin
                        issue_cnt <= '0;
                        pend_req  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (mem_rd && mem_ready) issue_cnt <= issue_cnt + 1'b1;
                    if (rd_req) pend_req <= 1'b1;
                    if (base_load) begin
                        pend_load <= 1'b1;
                        pend_base <= base_addr;
                    end
                end
                DONE: begin
                    if (rd_req) pend_req <= 1'b1;
                    pend_load <= 1'b0;
                    if (load_now) begin
                        ptr      <= load_base;
                        line_cnt <= '0;
                    end else if (num_lines != '0 && cnt_inc == num_lines) begin
                        ptr      <= base_addr;
                        line_cnt <= '0;
                    end else begin
                        ptr      <= ptr + ADDR_W'(WORDS);
                        line_cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_weight_responder.sv
// tb_sdram_weight_responder: directed bench with an in-order memory model returning data = address[15:0].
module tb_sdram_weight_responder;
    import sdram_resp_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, rd_req = 1'b0, base_load = 1'b0;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [23:0] base_addr = '0;
    logic [11:0] num_lines = '0;
    logic [15:0] mem_rdata = '0;
    line_t       rd_buf;
    logic        rd_done, mem_rd, busy, err;
    logic [23:0] mem_addr;

    always #5 clk = ~clk;

    sdram_weight_responder dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_buf(rd_buf), .rd_done(rd_done),
        .base_addr(base_addr), .base_load(base_load), .num_lines(num_lines),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy), .err(err)
    );

    int checks = 0, failures = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, unstable = 0, rv_cnt = 0;
    int lat_min = 2, lat_max = 2, spur_req = 0, spur_seen = 0, last_due = 0;
    bit rand_ready = 1'b0;
    logic [23:0] acc_log[$];
    line_t lines[$];
    line_t prev_buf = '0;
    typedef struct {logic [15:0] d; int due;} resp_t;
    resp_t q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int lat, due;
        if (reset) begin
            q.delete();
            mem_rvalid = 1'b0;
            mem_ready  = 1'b0;
            last_due   = 0;
        end else begin
            mem_rvalid = 1'b0;
            if (spur_req != spur_seen) begin
                spur_seen  = spur_req;
                mem_rvalid = 1'b1;
                mem_rdata  = 16'hdead;
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = q[0].d;
                void'(q.pop_front());
                rv_cnt++;
            end
            mem_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
            if (mem_rd && mem_ready) begin
                lat = int'($urandom_range(lat_max, lat_min));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                q.push_back('{mem_addr[15:0], due});
                acc_log.push_back(mem_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (rd_done) begin
            done_cnt++;
            done_cyc = cyc;
            lines.push_back(rd_buf);
        end
        if (!reset && !rd_done && rd_buf !== prev_buf) unstable++;
        prev_buf = rd_buf;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [23:0] a);
        base_addr = a;
        base_load = 1'b1;
        tick(1);
        base_load = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL wait_done timeout got=%0d want=%0d", done_cnt, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks += 6;
        if (rd_done !== 1'b0) begin failures++; $display("FAIL reset_rd_done got=%b want=0", rd_done); end
        if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%b want=0", mem_rd); end
        if (mem_addr !== 24'h0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
        if (rd_buf !== '0) begin failures++; $display("FAIL reset_rd_buf got=%h want=0", rd_buf); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_single();
        int a0, n0, r_cyc;
        a0 = acc_log.size();
        n0 = done_cnt;
        pulse_load(24'h000100);
        rd_req = 1'b1;
        r_cyc = cyc;
        tick(1);
        rd_req = 1'b0;
        wait_done(n0 + 1, 200);
        checks += 2;
        if (done_cyc - r_cyc + 1 !== 20) begin failures++; $display("FAIL single_latency got=%0d want=20", done_cyc - r_cyc + 1); end
        if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b want=0", err); end
        for (int i = 0; i < 16; i++) begin
            checks += 2;
            if (acc_log[a0+i] !== 24'(32'h100 + i)) begin failures++; $display("FAIL single_addr[%0d] got=%h want=%h", i, acc_log[a0+i], 24'(32'h100 + i)); end
            if (rd_buf[i] !== 16'(32'h100 + i)) begin failures++; $display("FAIL single_buf[%0d] got=%h want=%h", i, rd_buf[i], 16'(32'h100 + i)); end
        end
        tick(10);
        checks += 2;
        if (done_cnt !== n0 + 1) begin failures++; $display("FAIL single_done_count got=%0d want=%0d", done_cnt, n0 + 1); end
        if (acc_log.size() !== a0 + 16) begin failures++; $display("FAIL single_issue_count got=%0d want=%0d", acc_log.size() - a0, 16); end
    endtask

    task automatic test_wrap();
        int a0, n0;
        logic [23:0] exp_first[4];
        exp_first[0] = 24'h100; exp_first[1] = 24'h110; exp_first[2] = 24'h120; exp_first[3] = 24'h100;
        num_lines = 12'd3;
        a0 = acc_log.size();
        n0 = done_cnt;
        pulse_load(24'h000100);
        rd_req = 1'b1;
        wait_done(n0 + 3, 400);
        rd_req = 1'b0;
        wait_done(n0 + 4, 200);
        tick(30);
        checks += 3;
        if (done_cnt !== n0 + 4) begin failures++; $display("FAIL wrap_done_count got=%0d want=%0d", done_cnt - n0, 4); end
        if (busy !== 1'b0) begin failures++; $display("FAIL wrap_idle got=%b want=0", busy); end
        if (acc_log.size() !== a0 + 64) begin failures++; $display("FAIL wrap_issue_count got=%0d want=64", acc_log.size() - a0); end
        for (int l = 0; l < 4; l++) begin
            checks += 2;
            if (acc_log[a0+16*l] !== exp_first[l]) begin failures++; $display("FAIL wrap_line_addr[%0d] got=%h want=%h", l, acc_log[a0+16*l], exp_first[l]); end
            if (lines[n0+l][15] !== 16'(exp_first[l] + 24'hf)) begin failures++; $display("FAIL wrap_line_last[%0d] got=%h want=%h", l, lines[n0+l][15], 16'(exp_first[l] + 24'hf)); end
        end
        num_lines = 12'd0;
    endtask

    task automatic test_random();
        int a0, n0, u0;
        line_t old;
        rand_ready = 1'b1;
        lat_min = 1;
        lat_max = 5;
        a0 = acc_log.size();
        n0 = done_cnt;
        u0 = unstable;
        old = rd_buf;
        pulse_load(24'h000300);
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        tick(8);
        checks++;
        if (rd_buf !== old) begin failures++; $display("FAIL random_mid_buf got=%h want=%h", rd_buf, old); end
        wait_done(n0 + 1, 600);
        for (int i = 0; i < 16; i++) begin
            checks += 2;
            if (acc_log[a0+i] !== 24'(32'h300 + i)) begin failures++; $display("FAIL random_addr[%0d] got=%h want=%h", i, acc_log[a0+i], 24'(32'h300 + i)); end
            if (rd_buf[i] !== 16'(32'h300 + i)) begin failures++; $display("FAIL random_buf[%0d] got=%h want=%h", i, rd_buf[i], 16'(32'h300 + i)); end
        end
        tick(10);
        checks += 2;
        if (unstable !== u0) begin failures++; $display("FAIL random_stable got=%0d want=%0d", unstable, u0); end
        if (err !== 1'b0) begin failures++; $display("FAIL random_err got=%b want=0", err); end
        rand_ready = 1'b0;
        lat_min = 2;
        lat_max = 2;
    endtask

    task automatic test_midload();
        int a0, n0, k;
        a0 = acc_log.size();
        n0 = done_cnt;
        pulse_load(24'h000100);
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        k = 0;
        while (acc_log.size() < a0 + 5 && k < 50) begin
            tick(1);
            k++;
        end
        base_addr = 24'h002000;
        base_load = 1'b1;
        rd_req = 1'b1;
        tick(1);
        base_load = 1'b0;
        rd_req = 1'b0;
        wait_done(n0 + 2, 400);
        checks += 4;
        if (acc_log[a0] !== 24'h100) begin failures++; $display("FAIL midload_first got=%h want=000100", acc_log[a0]); end
        if (acc_log[a0+15] !== 24'h10f) begin failures++; $display("FAIL midload_last got=%h want=00010f", acc_log[a0+15]); end
        if (acc_log[a0+16] !== 24'h2000) begin failures++; $display("FAIL midload_next_first got=%h want=002000", acc_log[a0+16]); end
        if (acc_log[a0+31] !== 24'h200f) begin failures++; $display("FAIL midload_next_last got=%h want=00200f", acc_log[a0+31]); end
        for (int i = 0; i < 16; i++) begin
            checks += 2;
            if (lines[n0][i] !== 16'(32'h100 + i)) begin failures++; $display("FAIL midload_line0[%0d] got=%h want=%h", i, lines[n0][i], 16'(32'h100 + i)); end
            if (rd_buf[i] !== 16'(32'h2000 + i)) begin failures++; $display("FAIL midload_line1[%0d] got=%h want=%h", i, rd_buf[i], 16'(32'h2000 + i)); end
        end
        tick(10);
    endtask

    task automatic test_spurious();
        int n0;
        line_t old;
        tick(5);
        old = rd_buf;
        spur_req++;
        tick(2);
        checks += 3;
        if (err !== 1'b1) begin failures++; $display("FAIL spur_err got=%b want=1", err); end
        if (rd_buf !== old) begin failures++; $display("FAIL spur_buf got=%h want=%h", rd_buf, old); end
        if (busy !== 1'b0) begin failures++; $display("FAIL spur_busy got=%b want=0", busy); end
        tick(5);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL spur_err_sticky got=%b want=1", err); end
        n0 = done_cnt;
        pulse_load(24'h000400);
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        wait_done(n0 + 1, 200);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rd_buf[i] !== 16'(32'h400 + i)) begin failures++; $display("FAIL spur_fetch[%0d] got=%h want=%h", i, rd_buf[i], 16'(32'h400 + i)); end
        end
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL spur_err_after got=%b want=1", err); end
        tick(5);
    endtask

    task automatic test_reset_mid();
        int a0, n0, r0, k;
        n0 = done_cnt;
        r0 = rv_cnt;
        pulse_load(24'h000500);
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        k = 0;
        while (rv_cnt < r0 + 7 && k < 50) begin
            tick(1);
            k++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(3);
        checks += 6;
        if (rd_done !== 1'b0) begin failures++; $display("FAIL rmid_rd_done got=%b want=0", rd_done); end
        if (mem_rd !== 1'b0) begin failures++; $display("FAIL rmid_mem_rd got=%b want=0", mem_rd); end
        if (mem_addr !== 24'h0) begin failures++; $display("FAIL rmid_mem_addr got=%h want=0", mem_addr); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", busy); end
        if (err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b want=0", err); end
        if (rd_buf !== '0) begin failures++; $display("FAIL rmid_rd_buf got=%h want=0", rd_buf); end
        reset = 1'b0;
        tick(10);
        checks++;
        if (done_cnt !== n0) begin failures++; $display("FAIL rmid_no_done got=%0d want=%0d", done_cnt, n0); end
        a0 = acc_log.size();
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        wait_done(n0 + 1, 200);
        checks++;
        if (acc_log[a0] !== 24'h0) begin failures++; $display("FAIL rmid_fresh_addr got=%h want=000000", acc_log[a0]); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rd_buf[i] !== 16'(i)) begin failures++; $display("FAIL rmid_fresh_buf[%0d] got=%h want=%h", i, rd_buf[i], 16'(i)); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_random();
        test_midload();
        test_spurious();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
